// File: rtl/game_pkg.sv
// Shared types and constants for the tile-game flow controller and its beat divider.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        DONE      = 2'd3
    } game_state_t;

    localparam int FRAME_W_DEF = 8;
    localparam int HOLD_W      = 4;

    // A hold length of zero still occupies one beat.
    function automatic logic [HOLD_W-1:0] eff_len(input logic [HOLD_W-1:0] hold);
        return (hold == '0) ? HOLD_W'(1) : hold;
    endfunction

endpackage

// File: rtl/beat_divider.sv
// Beat timebase: counts 0..period-1 while run is high and pulses beat_tick on the last count.
module beat_divider #(
    parameter int BEAT_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(BEAT_CYCLES),
    parameter int PER_W       = $clog2(BEAT_CYCLES + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    output logic             beat_tick,
    output logic             beat_led
);

    logic [CNT_W-1:0] count;
    logic [PER_W-1:0] count_ext;
    logic             wrap;

    assign count_ext = PER_W'(count);
    assign wrap      = (count_ext == (period - PER_W'(1)));
    assign beat_tick = run && wrap;
    assign beat_led  = run && (count_ext < (period >> 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || wrap) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: start/countdown/play/done FSM, beat timebase and frame sequencing.
// Optional tempo ramp during PLAY is enabled by defining TEMPO_RAMP_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BEAT_CYCLES     = 50_000_000,
    parameter int SONG_LEN        = 11,
    parameter int FRAME_W         = FRAME_W_DEF,
    parameter int COUNTDOWN_BEATS = 3,
    parameter int MIN_BEAT_CYCLES = 12_500_000,
    parameter int RAMP_STEP       = 2_500_000,
    parameter int RAMP_FRAMES     = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               start_req,
    input  logic               abort,
    input  logic [HOLD_W-1:0]  hold_length,
    output logic [FRAME_W-1:0] game_frame,
    output logic               beat_tick,
    output logic               beat_led,
    output logic               score_en,
    output logic [3:0]         countdown,
    output logic               playing,
    output logic               done
);

    localparam int PER_W = $clog2(BEAT_CYCLES + 1);

    game_state_t        state, state_next;
    logic [FRAME_W-1:0] frame_next;
    logic [3:0]         countdown_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next, eff;
    logic               sync1, sync2, sync3, start_pulse;
    logic               run, frame_adv;
    logic [PER_W-1:0]   period;

    // start_req comes from a key, so it is synchronised before edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= start_req;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_pulse = sync2 && !sync3;
    assign run         = ((state == COUNTDOWN) || (state == PLAY)) && !abort;

    beat_divider #(
        .BEAT_CYCLES(BEAT_CYCLES)
    ) u_beat_divider (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .run      (run),
        .period   (period),
        .beat_tick(beat_tick),
        .beat_led (beat_led)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            game_frame <= '0;
            countdown  <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            game_frame <= frame_next;
            countdown  <= countdown_next;
            hold_cnt   <= hold_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_next     = game_frame;
        countdown_next = countdown;
        hold_next      = hold_cnt;
        score_en       = 1'b0;
        frame_adv      = 1'b0;
        eff            = eff_len(hold_length);

        case (state)
            IDLE, DONE: begin
                if (start_pulse) begin
                    state_next     = COUNTDOWN;
                    countdown_next = 4'(COUNTDOWN_BEATS);
                    frame_next     = '0;
                    hold_next      = '0;
                end
            end
            COUNTDOWN: begin
                if (beat_tick) begin
                    if (countdown == 4'd1) begin
                        state_next     = PLAY;
                        countdown_next = '0;
                        hold_next      = '0;
                        frame_next     = '0;
                    end else begin
                        countdown_next = countdown - 4'd1;
                    end
                end
            end
            PLAY: begin
                if (beat_tick) begin
                    score_en = 1'b1;
                    if ((hold_cnt + HOLD_W'(1)) == eff) begin
                        hold_next = '0;
                        if (game_frame == FRAME_W'(SONG_LEN - 1)) begin
                            state_next = DONE;
                        end else begin
                            frame_next = game_frame + FRAME_W'(1);
                            frame_adv  = 1'b1;
                        end
                    end else begin
                        hold_next = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides every transition and pulse decided above.
        if (abort) begin
            state_next     = IDLE;
            frame_next     = '0;
            countdown_next = '0;
            hold_next      = '0;
            score_en       = 1'b0;
            frame_adv      = 1'b0;
        end
    end

`ifdef TEMPO_RAMP_EN
    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    logic [RAMP_W-1:0] ramp_cnt;
    logic              enter_countdown;

    assign enter_countdown = (state_next == COUNTDOWN) && (state != COUNTDOWN);

    // Frame advances only happen on a beat wrap, so a new period lands on a fresh beat.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            period   <= PER_W'(BEAT_CYCLES);
            ramp_cnt <= '0;
        end else if (enter_countdown) begin
            period   <= PER_W'(BEAT_CYCLES);
            ramp_cnt <= '0;
        end else if (frame_adv) begin
            if (ramp_cnt == RAMP_W'(RAMP_FRAMES - 1)) begin
                ramp_cnt <= '0;
                if ((int'(period) - RAMP_STEP) <= MIN_BEAT_CYCLES) begin
                    period <= PER_W'(MIN_BEAT_CYCLES);
                end else begin
                    period <= period - PER_W'(RAMP_STEP);
                end
            end else begin
                ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
        end
    end
`else
    assign period = PER_W'(BEAT_CYCLES);
`endif

    assign playing = (state == PLAY);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-plus-random bench for game_sequencer, checked against a timeline model of the game.
module tb_game_sequencer;

    localparam int BC = 4;
    localparam int SL = 3;
    localparam int CB = 2;
    localparam int FW = 8;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n;
    logic          start_req;
    logic          abort;
    logic [3:0]    hold_length;
    logic [FW-1:0] game_frame;
    logic          beat_tick, beat_led, score_en, playing, done;
    logic [3:0]    countdown;

    int checks   = 0;
    int failures = 0;
    int holds[SL];
    int exp_frame, exp_cd, exp_tick, exp_led, exp_score, exp_play, exp_done;

    always #5 CLOCK_50 = ~CLOCK_50;

    game_sequencer #(
        .BEAT_CYCLES    (BC),
        .SONG_LEN       (SL),
        .FRAME_W        (FW),
        .COUNTDOWN_BEATS(CB)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .start_req  (start_req),
        .abort      (abort),
        .hold_length(hold_length),
        .game_frame (game_frame),
        .beat_tick  (beat_tick),
        .beat_led   (beat_led),
        .score_en   (score_en),
        .countdown  (countdown),
        .playing    (playing),
        .done       (done)
    );

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int game_len();
        int total = CB * BC;
        for (int f = 0; f < SL; f++) total += eff(holds[f]) * BC;
        return total;
    endfunction

    // Expected outputs k cycles after COUNTDOWN is entered, derived from beat arithmetic.
    task automatic model(input int k);
        int lead, acc, p;
        lead = CB * BC;
        exp_frame = 0; exp_cd = 0; exp_tick = 0; exp_led = 0;
        exp_score = 0; exp_play = 0; exp_done = 0;
        if (k < lead) begin
            exp_cd   = CB - k / BC;
            exp_tick = (k % BC == BC - 1);
            exp_led  = (k % BC < BC / 2);
        end else if (k < game_len()) begin
            p         = k - lead;
            exp_play  = 1;
            exp_tick  = (p % BC == BC - 1);
            exp_score = exp_tick;
            exp_led   = (p % BC < BC / 2);
            acc = 0;
            for (int f = 0; f < SL; f++) begin
                if (p >= acc && p < acc + eff(holds[f]) * BC) exp_frame = f;
                acc += eff(holds[f]) * BC;
            end
        end else begin
            exp_done  = 1;
            exp_frame = SL - 1;
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string where);
        check({where, " game_frame"}, 32'(game_frame), 32'(exp_frame));
        check({where, " countdown"},  32'(countdown),  32'(exp_cd));
        check({where, " beat_tick"},  32'(beat_tick),  32'(exp_tick));
        check({where, " beat_led"},   32'(beat_led),   32'(exp_led));
        check({where, " score_en"},   32'(score_en),   32'(exp_score));
        check({where, " playing"},    32'(playing),    32'(exp_play));
        check({where, " done"},       32'(done),       32'(exp_done));
    endtask

    task automatic check_idle(input string where);
        exp_frame = 0; exp_cd = 0; exp_tick = 0; exp_led = 0;
        exp_score = 0; exp_play = 0; exp_done = 0;
        check_output(where);
    endtask

    // Rising edge on start_req; COUNTDOWN begins three clocks later.
    task automatic apply_stimulus();
        start_req = 1'b0;
        step();
        step();
        start_req = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic run_game(input int kend, input int abort_k);
        for (int k = 0; k < kend; k++) begin
            if (k == 0) start_req = 1'b0;
            model(k);
            hold_length = 4'(holds[exp_frame]);
            check_output($sformatf("k=%0d", k));
            if (k == abort_k - 2) start_req = 1'b1;
            if (k == abort_k) begin
                abort = 1'b1;
                #1;
                check("abort score_en", 32'(score_en), 32'd0);
                step();
                abort = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    check_idle($sformatf("after_abort+%0d", i));
                    step();
                end
                return;
            end
            step();
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start_req   = 1'b0;
        abort       = 1'b0;
        hold_length = 4'd0;
        #12;
        check_idle("reset");
        reset_n = 1'b1;
        step();
        step();
        check_idle("idle");

        $display("[TB] game 1: long first note, zero-length second note");
        holds[0] = 3;
        holds[1] = 0;
        holds[2] = $urandom_range(0, 5);
        apply_stimulus();
        run_game(game_len() + 4, -1);

        $display("[TB] game 2: restart from DONE with random holds");
        for (int f = 0; f < SL; f++) holds[f] = $urandom_range(0, 5);
        apply_stimulus();
        run_game(game_len() + 4, -1);

        $display("[TB] game 3: abort with simultaneous beat_tick and start pulse");
        holds[0] = 1;
        holds[1] = $urandom_range(1, 5);
        holds[2] = $urandom_range(0, 5);
        apply_stimulus();
        run_game(game_len() + 4, CB * BC + 7);

        $display("[TB] game 4: asynchronous reset mid-countdown, then full game");
        for (int f = 0; f < SL; f++) holds[f] = $urandom_range(0, 5);
        apply_stimulus();
        run_game(6, -1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("post_reset+%0d", i));
        end
        apply_stimulus();
        run_game(game_len() + 4, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central game-flow controller for the tile game.
- Owns the start/countdown/play/done state machine.
- Generates the beat timebase from CLOCK_50 and advances the song frame index, honouring each note's hold length.
- Tells the scorer when to sample.
- Sits between the user keys and the note engine/scorer; replaces the free-running game clock and frame counter with one sequenced, reset-safe controller.

Parameters:
- BEAT_CYCLES, 50_000_000: CLOCK_50 cycles per beat (min 2).
- SONG_LEN, 11: number of frames in the song (1..2**FRAME_W).
- FRAME_W, 8: game_frame width.
- COUNTDOWN_BEATS, 3: lead-in beats before frame 0 (1..15).
- MIN_BEAT_CYCLES, 12_500_000: tempo floor; used only with TEMPO_RAMP_EN.
- RAMP_STEP, 2_500_000: cycles removed per ramp; used only with TEMPO_RAMP_EN.
- RAMP_FRAMES, 4: frames between ramps; used only with TEMPO_RAMP_EN.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- start_req  in  1  start request, active-high level; asynchronous to the clock (debounced key)
- abort  in  1  synchronous soft abort, active-high
- hold_length  in  4  beats for the current note, from the engine (combinational on game_frame)
- game_frame  out  FRAME_W  current song frame
- beat_tick  out  1  one-cycle pulse at the end of each beat
- beat_led  out  1  metronome: high during the first half of each beat
- score_en  out  1  one-cycle pulse telling the scorer to sample the key match
- countdown  out  4  lead-in beats remaining; 0 outside COUNTDOWN
- playing  out  1  high in PLAY
- done  out  1  high in DONE

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE. game_frame=0, countdown=0, all pulses/flags=0, beat counter=0, hold counter=0, sync flops=0.
- start_req: 2-FF synchroniser, then rising-edge detect → start_pulse, 3 cycles after the pin edge.
- States: IDLE, COUNTDOWN, PLAY, DONE.
- Beat counter:
  - Runs only in COUNTDOWN and PLAY; held at 0 in IDLE and DONE.
  - Counts 0..period-1. beat_tick=1 in the cycle where count==period-1, then wraps to 0.
  - beat_led = (count < period/2) while running; 0 otherwise.
- IDLE:
  - On start_pulse → COUNTDOWN; countdown=COUNTDOWN_BEATS; beat counter=0; game_frame=0.
- COUNTDOWN:
  - On each beat_tick, countdown decrements.
  - When beat_tick arrives with countdown==1 → PLAY; countdown=0; hold counter=0; game_frame=0.
  - start_pulse is ignored.
- PLAY:
  - On each beat_tick: score_en=1 in the same cycle.
  - eff_len = (hold_length==0) ? 1 : hold_length.
  - If hold_cnt+1 == eff_len: note complete, hold_cnt=0. Otherwise hold_cnt increments.
  - Note complete with game_frame < SONG_LEN-1: game_frame increments.
  - Note complete with game_frame == SONG_LEN-1: → DONE; game_frame holds.
  - start_pulse is ignored.
- DONE:
  - done=1; game_frame holds the last value.
  - start_pulse → COUNTDOWN (fresh game, same as from IDLE).
- abort: from any state, next state IDLE with all outputs cleared as at reset. abort wins over a simultaneous start_pulse or beat_tick.
- reset_n asserted mid-beat: immediate return to reset values; no partial pulses afterwards.
- Latency:
  - game_frame updates the cycle after the beat_tick that completes a note.
  - hold_length is read live; the engine must present the new frame's value within 1 cycle.
- Widths:
  - hold_cnt is 4 bits; never exceeds 14.
  - Beat counter width = $clog2(BEAT_CYCLES).

Optional Feature:
- TEMPO_RAMP_EN defined:
  - A period register loads BEAT_CYCLES on entry to COUNTDOWN.
  - In PLAY, every RAMP_FRAMES frame advances, period -= RAMP_STEP, saturating at MIN_BEAT_CYCLES.
  - A new period takes effect at the next beat wrap.
- Not defined: period is the constant BEAT_CYCLES; no ramp logic is present.

Decomposition:
- Package game_pkg:
  - state encoding (IDLE=0, COUNTDOWN=1, PLAY=2, DONE=3)
  - FRAME_W default
  - HOLD_W=4
- Sub-module beat_divider (CLOCK_50, reset_n, run, period → beat_tick, beat_led). Instantiated once; period port is constant unless TEMPO_RAMP_EN.

Test Plan:
All scenarios use BEAT_CYCLES=4, SONG_LEN=3, COUNTDOWN_BEATS=2 unless stated.
- Reset, then start_req high: COUNTDOWN entered 3 cycles after the pin edge; countdown=2. It reads 1 after 4 cycles. After 8 cycles: playing=1, game_frame=0.
- PLAY with hold_length=1 for all frames: game_frame steps 0→1→2 every 4 cycles with score_en pulses. After 3 beats: done=1, game_frame=2, beat_tick stops.
- hold_length=3 on frame 0: frame 0 lasts 3 beats (12 cycles), producing 3 score_en pulses. hold_length=0 on frame 1: frame 1 lasts 1 beat.
- abort asserted in PLAY at frame 1, same cycle as beat_tick and start_req edge: next cycle IDLE, game_frame=0, no score_en.
- reset_n pulsed low mid-COUNTDOWN: outputs clear immediately. A later start_req restarts with countdown=2. start_req while in DONE restarts at frame 0.
- TEMPO_RAMP_EN, BEAT_CYCLES=8, RAMP_STEP=2, MIN=4, RAMP_FRAMES=1, SONG_LEN=5: beat periods are 8,6,4,4,4 cycles in PLAY.
